sample_frame_packer: RTL
========================

Name: sample_frame_packer

Overview:
- Downstream of the demodulator top level: snapshots the processed 32-bit results (counter, OPD, shear and pointing words) on each sample tick.
- Buffers whole frames in a small frame FIFO.
- Streams frames one 32-bit word per beat over a valid/ready interface to the host transport (PS DMA / UART bridge).
- Frames are atomic: a frame is either fully transmitted or dropped whole, and a drop is counted.

Parameters:
- NUM_WORDS, 23, payload words per frame (counter + 22 processed values); legal range 1..255.
- DEPTH_FRAMES, 4, frame slots in the buffer; power of two, ≥2.

Ports:
- clk_i  input  1  system clock.
- reset_ni  input  1  reset, asynchronous, active-low.
- tick_i  input  1  one-cycle strobe: capture data_i this cycle.
- data_i  input  32*NUM_WORDS  payload; word k = data_i[32k+31:32k], word 0 sent first.
- m_data_o  output  32  stream word.
- m_valid_o  output  1  stream word valid.
- m_ready_i  input  1  sink ready.
- m_last_o  output  1  high on final word of a frame.
- frames_pending_o  output  $clog2(DEPTH_FRAMES)+1  occupied slots, including the frame being streamed.
- overflow_count_o  output  16  dropped-frame count, saturating.

Behaviour:
- Reset: asserting reset_ni low asynchronously clears all outputs to 0 (m_valid_o, m_last_o, m_data_o, frames_pending_o, overflow_count_o), clears write/read pointers, word index and FSM state. Slot contents are don't-care after reset. Reset mid-frame abandons the partial frame with no further beats.
- Capture:
  - On tick_i with a free slot, all NUM_WORDS words are written into slot wr_ptr in one cycle, wr_ptr wraps modulo DEPTH_FRAMES, and count increments.
  - Free slot means count < DEPTH_FRAMES, or count == DEPTH_FRAMES and the final beat of the head frame (m_valid_o & m_ready_i & m_last_o) completes in the same cycle. In that case the tick is accepted and count is unchanged.
  - If tick_i arrives with no free slot, the frame is dropped, buffer contents are unchanged, and overflow_count_o increments, holding at 16'hFFFF.
- Read FSM, states IDLE and STREAM:
  - IDLE → STREAM when count > 0.
  - Transition to STREAM: word index = 0 and m_valid_o = 1 from the next cycle. Latency: a tick into an empty buffer at cycle n gives the first beat valid at n+1.
  - STREAM: a beat transfers when m_valid_o & m_ready_i, then the word index increments.
  - Final beat (index NUM_WORDS-1, m_last_o = 1): rd_ptr advances and count decrements.
    - If another frame is pending (count after update > 0), the FSM stays in STREAM and word 0 of the next frame is presented the following cycle with no bubble.
    - Otherwise the FSM returns to IDLE and m_valid_o drops.
- Handshake rules:
  - Once m_valid_o is high, m_valid_o, m_data_o and m_last_o stay stable until the transfer.
  - m_valid_o never depends combinationally on m_ready_i.
  - m_data_o and m_last_o are registered.
- Simultaneous tick and final beat with count == 1: count stays 1 and the new frame streams next with no bubble.
- frames_pending_o is the registered count. The count increments on accepted capture and decrements on final beat.
- Arithmetic: word index is 8 bits. Pointers are $clog2(DEPTH_FRAMES) bits and wrap naturally. No arithmetic is applied to payload data.

Optional Feature:
- Macro FRAME_HEADER_EN.
- When defined, each frame is prefixed by one header word {8'hA5, NUM_WORDS[7:0], seq[15:0]}, giving NUM_WORDS+1 beats per frame:
  - seq is a 16-bit counter that increments on each accepted capture and wraps.
  - A frame's seq is the value latched at its capture, so a gap in seq reveals drops.
  - The header is the first beat; m_last_o is still only on the final payload word.
- When undefined, a frame is exactly NUM_WORDS payload beats and no seq logic exists.

Test Plan:
- Single frame, m_ready_i held high, NUM_WORDS=23, data word k = 32'h1000_0000+k, tick at cycle 10 → beats at cycles 11..33 carry 10000000..10000016; m_last_o only at cycle 33; m_valid_o low at 34; frames_pending_o 1 then 0.
- Backpressure: m_ready_i toggles 1,0,0,1 repeating → every word delivered exactly once in order; m_data_o stable while valid & !ready.
- Overflow: m_ready_i=0, 6 ticks with DEPTH_FRAMES=4 → frames_pending_o=4, overflow_count_o=2; after ready, exactly frames 1..4 arrive (word 0 = 1..4).
- Full plus simultaneous tick on last beat: count 4, tick coincides with final beat → tick accepted, overflow_count_o unchanged, 4 more frames follow back-to-back with no idle cycle between frames.
- Async reset mid-frame: reset_ni low at word 7 of a frame → all outputs 0 within the same cycle without a clock edge; after release, the next tick yields a clean frame starting at word 0.
- Saturation (force count near max): 65,537 drops → overflow_count_o holds 16'hFFFF. With FRAME_HEADER_EN defined, two frames → headers A5_17_0000 and A5_17_0001.

Source files
------------

// File: rtl/sample_frame_packer.sv
// Frame packer: snapshots NUM_WORDS x 32-bit results on tick_i into a small frame FIFO and
// streams them one word per valid/ready beat. Define FRAME_HEADER_EN to prefix a header beat.
module sample_frame_packer #(
  parameter int NUM_WORDS    = 23,
  parameter int DEPTH_FRAMES = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          tick_i,
  input  logic [32*NUM_WORDS-1:0]       data_i,
  output logic [31:0]                   m_data_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic                          m_last_o,
  output logic [$clog2(DEPTH_FRAMES):0] frames_pending_o,
  output logic [15:0]                   overflow_count_o
);

  localparam int PTR_W = $clog2(DEPTH_FRAMES);
  localparam int CNT_W = PTR_W + 1;
`ifdef FRAME_HEADER_EN
  localparam int HDR_BEATS = 1;
`else
  localparam int HDR_BEATS = 0;
`endif
  localparam int               BEATS     = NUM_WORDS + HDR_BEATS;
  localparam logic [7:0]       LAST_IDX  = 8'(BEATS - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_FRAMES);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  logic [32*NUM_WORDS-1:0] mem_r [DEPTH_FRAMES];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic [15:0]             ovf_r;
  logic [7:0]              word_idx_r;
  logic [31:0]             m_data_r;
  logic                    m_valid_r;
  logic                    m_last_r;
  state_e                  state_r;
  state_e                  state_next_s;

  logic                    beat_s;
  logic                    pop_s;
  logic                    free_s;
  logic                    capture_s;
  logic                    drop_s;
  logic [CNT_W-1:0]        count_next_s;
  logic [PTR_W-1:0]        head_ptr_s;
  logic                    head_bypass_s;
  logic [32*NUM_WORDS-1:0] head_frame_s;
  logic [32*NUM_WORDS-1:0] cur_frame_s;
  logic [32*NUM_WORDS-1:0] sel_frame_s;
  logic                    load_s;
  logic                    sel_head_s;
  logic [7:0]              idx_next_s;
  logic                    valid_next_s;
  logic                    last_next_s;
  logic [31:0]             data_next_s;
  logic [31:0]             beat_data_s;

`ifdef FRAME_HEADER_EN
  localparam logic [7:0] NW8 = 8'(NUM_WORDS);
  logic [15:0] seq_r;
  logic [15:0] seq_mem_r [DEPTH_FRAMES];
  logic [15:0] head_seq_s;
`endif

  function automatic logic [31:0] payload_word(input logic [32*NUM_WORDS-1:0] frame,
                                               input logic [7:0] idx);
    return frame[32*int'(idx) +: 32];
  endfunction

  // Handshake, capture admission and occupancy bookkeeping
  always_comb begin
    beat_s       = m_valid_r & m_ready_i;
    pop_s        = beat_s & m_last_r;
    free_s       = (count_r < DEPTH_CNT) || ((count_r == DEPTH_CNT) && pop_s);
    capture_s    = tick_i & free_s;
    drop_s       = tick_i & ~free_s;
    count_next_s = count_r + CNT_W'(capture_s) - CNT_W'(pop_s);
  end

  // Head-of-queue frame for word 0; an empty queue forwards the frame being captured now
  always_comb begin
    head_ptr_s    = rd_ptr_r + PTR_W'(pop_s);
    head_bypass_s = ((count_r - CNT_W'(pop_s)) == {CNT_W{1'b0}});
    cur_frame_s   = mem_r[rd_ptr_r];
    if (head_bypass_s) begin
      head_frame_s = data_i;
    end else begin
      head_frame_s = mem_r[head_ptr_s];
    end
`ifdef FRAME_HEADER_EN
    if (head_bypass_s) begin
      head_seq_s = seq_r;
    end else begin
      head_seq_s = seq_mem_r[head_ptr_s];
    end
`endif
  end

  // Read FSM state register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Read FSM next state
  always_comb begin
    case (state_r)
      IDLE:    state_next_s = (capture_s || (count_r != {CNT_W{1'b0}})) ? STREAM : IDLE;
      STREAM:  state_next_s = (pop_s && (count_next_s == {CNT_W{1'b0}})) ? IDLE : STREAM;
      default: state_next_s = IDLE;
    endcase
  end

  // Read FSM outputs: next values of the registered stream port
  always_comb begin
    load_s       = 1'b0;
    sel_head_s   = 1'b0;
    idx_next_s   = word_idx_r;
    valid_next_s = m_valid_r;
    case (state_r)
      IDLE: begin
        if (state_next_s == STREAM) begin
          load_s       = 1'b1;
          sel_head_s   = 1'b1;
          idx_next_s   = 8'd0;
          valid_next_s = 1'b1;
        end else begin
          valid_next_s = 1'b0;
        end
      end
      STREAM: begin
        if (beat_s && m_last_r && (state_next_s == STREAM)) begin
          load_s       = 1'b1;
          sel_head_s   = 1'b1;
          idx_next_s   = 8'd0;
          valid_next_s = 1'b1;
        end else if (beat_s && m_last_r) begin
          idx_next_s   = 8'd0;
          valid_next_s = 1'b0;
        end else if (beat_s) begin
          load_s       = 1'b1;
          idx_next_s   = word_idx_r + 8'd1;
          valid_next_s = 1'b1;
        end else begin
          valid_next_s = m_valid_r;
        end
      end
      default: begin
        idx_next_s   = 8'd0;
        valid_next_s = 1'b0;
      end
    endcase

    sel_frame_s = sel_head_s ? head_frame_s : cur_frame_s;
`ifdef FRAME_HEADER_EN
    if (idx_next_s == 8'd0) begin
      beat_data_s = {8'hA5, NW8, head_seq_s};
    end else begin
      beat_data_s = payload_word(sel_frame_s, idx_next_s - 8'd1);
    end
`else
    beat_data_s = payload_word(sel_frame_s, idx_next_s);
`endif

    if (load_s) begin
      data_next_s = beat_data_s;
      last_next_s = (idx_next_s == LAST_IDX);
    end else if (valid_next_s) begin
      data_next_s = m_data_r;
      last_next_s = m_last_r;
    end else begin
      data_next_s = 32'h0;
      last_next_s = 1'b0;
    end
  end

  // Stream port registers and word index
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      m_data_r   <= 32'h0;
      m_valid_r  <= 1'b0;
      m_last_r   <= 1'b0;
      word_idx_r <= 8'd0;
    end else begin
      m_data_r   <= data_next_s;
      m_valid_r  <= valid_next_s;
      m_last_r   <= last_next_s;
      word_idx_r <= idx_next_s;
    end
  end

  // Pointers, occupancy and saturating drop counter
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      ovf_r    <= 16'h0;
    end else begin
      if (capture_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
      if (drop_s && (ovf_r != 16'hFFFF)) begin
        ovf_r <= ovf_r + 16'd1;
      end
    end
  end

  // Frame slot storage; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (capture_s) begin
      mem_r[wr_ptr_r] <= data_i;
`ifdef FRAME_HEADER_EN
      seq_mem_r[wr_ptr_r] <= seq_r;
`endif
    end
  end

`ifdef FRAME_HEADER_EN
  // Sequence number latched into each accepted frame
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      seq_r <= 16'h0;
    end else if (capture_s) begin
      seq_r <= seq_r + 16'd1;
    end
  end
`endif

  assign m_data_o         = m_data_r;
  assign m_valid_o        = m_valid_r;
  assign m_last_o         = m_last_r;
  assign frames_pending_o = count_r;
  assign overflow_count_o = ovf_r;

endmodule
